// File: rtl/note_arbiter.sv
// note_arbiter
//   Folds the seven debounced piano keys and the octave buttons into one
//   (octave, note) pair for the single-voice tone generator.
//   Last-pressed key wins. Once every key is up, the note keeps sounding for
//   RELEASE_CYCLES clock cycles and then goes silent.
//   All outputs are registered, and a key change shows up one edge later.
module note_arbiter #(
  parameter int          RELEASE_CYCLES = 25_000_000, // sustain length, >= 1
  parameter int          CNT_W          = 25,         // 2**CNT_W > RELEASE_CYCLES
  parameter logic [2:0]  DEFAULT_OCT    = 3'd3        // octave after reset
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic [6:0] keys,     // bit0 = C .. bit6 = B, 1 = pressed
  input  logic       oct_up,   // single-cycle pulse
  input  logic       oct_dn,   // single-cycle pulse
  output logic [2:0] octave,
  output logic [2:0] note,     // 0 = silent, 1..7 = C..B
  output logic       active
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_RELEASE
  } state_t;

  // Last count of the sustain. When rcnt_q reaches this value the voice
  // goes silent on the next edge, so the sustain lasts RELEASE_CYCLES edges.
  localparam logic [CNT_W-1:0] RCNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [6:0]       keys_q;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [2:0]       note_q, note_d;
  logic [2:0]       octave_q, octave_d;
  logic             active_q, active_d;
  logic [6:0]       press;

  // Returns the note code (index + 1) of the lowest set bit, or 0 if no bit
  // is set. C has the highest priority.
  function automatic logic [2:0] lowest_note(input logic [6:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i]) n = 3'(i + 1);
    end
    return n;
  endfunction

  // Returns the key mask that belongs to a note code. Code 0 gives an empty
  // mask.
  function automatic logic [6:0] note_mask(input logic [2:0] n);
    logic [6:0] m;
    m = 7'd0;
    for (int i = 0; i < 7; i++) begin
      if (n == 3'(i + 1)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // A key counts as a new press on the cycle its level rises.
  assign press = keys & ~keys_q;

  // Next-state logic for the voice: state, note and the sustain counter.
  always_comb begin
    // NOTE: every signal gets a default value before the case statement.
    // Without it, any path that does not assign a signal would infer a latch.
    state_d = state_q;
    note_d  = note_q;
    rcnt_d  = rcnt_q;

    unique case (state_q)
      S_IDLE: begin
        rcnt_d = '0;
        if (press != 7'd0) begin
          state_d = S_PLAY;
          note_d  = lowest_note(press);
        end
      end

      S_PLAY: begin
        rcnt_d = '0;
        if (press != 7'd0) begin
          // A new press beats any release in the same cycle. Re-pressing the
          // current key gives the same code, so the note stays the same.
          note_d = lowest_note(press);
        end else if (keys == 7'd0) begin
          state_d = S_RELEASE;
        end else if ((keys & note_mask(note_q)) == 7'd0) begin
          // The sounding key was let go but other keys are still held.
          note_d = lowest_note(keys);
        end
      end

      S_RELEASE: begin
        if (press != 7'd0) begin
          state_d = S_PLAY;
          note_d  = lowest_note(press);
          rcnt_d  = '0;
        end else if (rcnt_q == RCNT_LAST) begin
          state_d = S_IDLE;
          note_d  = 3'd0;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        note_d  = 3'd0;
        rcnt_d  = '0;
      end
    endcase

    // active is derived from the next note, so the two registers always agree.
    active_d = (note_d != 3'd0);
  end

  // Octave counter. It saturates at 0 and 7 and ignores the voice state.
  always_comb begin
    octave_d = octave_q;
    if (oct_up && !oct_dn && (octave_q != 3'd7)) begin
      octave_d = octave_q + 3'd1;
    end else if (oct_dn && !oct_up && (octave_q != 3'd0)) begin
      octave_d = octave_q - 3'd1;
    end
  end

  // State and output registers. rst is synchronous and overrides every input.
  always_ff @(posedge clk_100M) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the values from before the edge, so the order of
    // the statements below does not matter.
    if (rst) begin
      state_q  <= S_IDLE;
      keys_q   <= 7'd0;
      rcnt_q   <= '0;
      note_q   <= 3'd0;
      active_q <= 1'b0;
      octave_q <= DEFAULT_OCT;
    end else begin
      state_q  <= state_d;
      keys_q   <= keys;
      rcnt_q   <= rcnt_d;
      note_q   <= note_d;
      active_q <= active_d;
      octave_q <= octave_d;
    end
  end

  assign octave = octave_q;
  assign note   = note_q;
  assign active = active_q;

endmodule
